// File: rtl/riscblade_pkg.sv
// Shared riscblade definitions: datapath widths, opcode field and constants,
// fetch sequencer states and the instruction/PC buffer entry.
package riscblade_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam logic [PC_W-1:0] RESET_VECTOR = 16'h0000;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b1000;
  localparam logic [3:0] OP_ADDI   = 4'b0001;
  localparam logic [3:0] OP_LW     = 4'b1001;
  localparam logic [3:0] OP_SW_LO  = 4'b0010;
  localparam logic [3:0] OP_SW_HI  = 4'b1010;
  localparam logic [3:0] OP_BR_LO  = 4'b0011;
  localparam logic [3:0] OP_BR_HI  = 4'b1011;
  localparam logic [3:0] OP_JAL_LO = 4'b0100;
  localparam logic [3:0] OP_JAL_HI = 4'b1100;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction/PC buffer; slot0 is always the head so the read side
// is a plain register with no pointer mux.
module fetch_fifo
  import riscblade_pkg::*;
(
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // A simultaneous pop and push on a full buffer shifts and refills in one edge.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory sequencer feeding a 2-entry
// buffer. Define FETCH_BYPASS_EN to present a response in its own rvalid cycle.
module instr_fetch
  import riscblade_pkg::*;
(
  input  logic               CLK,
  input  logic               reset_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [PC_W-1:0]    pc_out,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            discard;
  logic            req_q;
  logic [PC_W-1:0] addr_q;

  fetch_entry_t    fifo_din;
  fetch_entry_t    fifo_head;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_count;
  logic [1:0]      count_next;
  logic            space_ok;
  logic            resp_live;
  logic            bypass_hit;
  logic            bypass_take;

  // addr_q is held from issue until the response returns, so it is the PC of the word.
  assign resp_live   = (state == FETCH_WAIT) && mem_rvalid && !discard;
  assign bypass_take = bypass_hit && instr_ready && !branch_taken;
  assign fifo_pop    = !fifo_empty && instr_ready && !branch_taken;
  assign fifo_push   = resp_live && !branch_taken && !bypass_take && (!fifo_full || fifo_pop);
  assign fifo_din    = '{pc: addr_q, instr: mem_rdata};
  assign count_next  = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
  assign space_ok    = (count_next < 2'd2);

  fetch_fifo u_fifo (
    .CLK     (CLK),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (branch_taken),
    .din     (fifo_din),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH_IDLE;
      pc      <= RESET_VECTOR;
      discard <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_VECTOR;
    end else if (branch_taken) begin
      pc <= branch_target;
      case (state)
        // A grant in the redirect cycle still leaves one stale response in flight.
        FETCH_REQ: begin
          if (mem_gnt) begin
            state   <= FETCH_WAIT;
            req_q   <= 1'b0;
            discard <= 1'b1;
          end else begin
            addr_q <= branch_target;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            state   <= FETCH_REQ;
            req_q   <= 1'b1;
            addr_q  <= branch_target;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: begin
          state  <= FETCH_REQ;
          req_q  <= 1'b1;
          addr_q <= branch_target;
        end
      endcase
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (space_ok) begin
            state  <= FETCH_REQ;
            req_q  <= 1'b1;
            addr_q <= pc;
          end
        end
        FETCH_REQ: begin
          if (mem_gnt) begin
            state <= FETCH_WAIT;
            req_q <= 1'b0;
            pc    <= pc + 16'd2;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            discard <= 1'b0;
            if (space_ok) begin
              state  <= FETCH_REQ;
              req_q  <= 1'b1;
              addr_q <= pc;
            end else begin
              state <= FETCH_IDLE;
            end
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit  = resp_live && fifo_empty;
  assign instr_valid = !fifo_empty || bypass_hit;
  assign instr       = bypass_hit ? mem_rdata : fifo_head.instr;
  assign pc_out      = bypass_hit ? addr_q    : fifo_head.pc;
`else
  assign bypass_hit  = 1'b0;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign pc_out      = fifo_head.pc;
`endif

  assign op = opcode_of(instr);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port mem_req, output, 1 bit: fetch read request to instruction memory.
REQ-004 SHALL have port mem_addr, output, 16 bits: byte address of the requested instruction.
REQ-005 SHALL have port mem_gnt, input, 1 bit: memory accepted the request this cycle.
REQ-006 SHALL have port mem_rvalid, input, 1 bit: read data is valid this cycle.
REQ-007 SHALL have port mem_rdata, input, 16 bits: fetched instruction word.
REQ-008 SHALL have port instr_valid, output, 1 bit: an instruction is presented to the control unit.
REQ-009 SHALL have port instr_ready, input, 1 bit: the control unit consumes the presented instruction.
REQ-010 SHALL have port instr, output, 16 bits: the presented instruction word.
REQ-011 SHALL have port op, output, 4 bits: always equal to instr[15:12].
REQ-012 SHALL have port pc_out, output, 16 bits: address of the presented instruction.
REQ-013 SHALL have port branch_taken, input, 1 bit: redirect request from the control unit.
REQ-014 SHALL have port branch_target, input, 16 bits: redirect address.

Function
REQ-015 SHALL keep a fetch PC that advances by 2 on each cycle where mem_req and mem_gnt are both high, wrapping from 0xFFFE to 0x0000.
REQ-016 SHALL sequence fetches through three states, with these transitions:
- IDLE -> REQ when (buffered entries + outstanding) < 2.
- REQ -> WAIT on mem_gnt.
- WAIT -> REQ or IDLE on mem_rvalid, applying the same space check.
REQ-017 SHALL allow at most one outstanding memory request.
REQ-018 SHALL hold mem_req high and mem_addr stable in REQ until mem_gnt is received.
REQ-019 SHALL write each accepted response into a 2-entry buffer, storing the instruction word and its PC together.
REQ-020 SHALL present the buffer head on instr, op and pc_out, with instr_valid high whenever the buffer is non-empty.
REQ-021 SHALL pop the buffer head on each cycle where instr_valid and instr_ready are both high.
REQ-022 SHALL hold instr, op and pc_out stable while instr_valid is high and instr_ready is low.
REQ-023 SHALL deliver data from a mem_rvalid cycle with instr_valid high on the next cycle, given an empty buffer and no bypass.
REQ-024 SHALL handle a response arriving in the same cycle as a pop with the buffer full by completing the pop and the write together, with no loss.
REQ-025 SHALL, on branch_taken, perform all of the following:
- flush the buffer;
- load branch_target into the PC;
- drive instr_valid low on the next cycle;
- mark any outstanding response for discard;
- enter REQ on the next cycle, or after the discarded response returns.
REQ-026 SHALL give branch_taken priority over a simultaneous instr_ready pop or mem_rvalid write.
REQ-027 SHALL drop a discarded response silently, without a buffer write.

Reset
REQ-028 SHALL, while reset_n is low, set:
- state IDLE;
- PC 0x0000;
- buffer empty;
- discard flag clear;
- mem_req 0 and mem_addr 0x0000;
- instr_valid 0, instr 0x0000, op 0x0 and pc_out 0x0000.
REQ-029 SHALL issue the first mem_req (address 0x0000) on the first rising edge after reset_n deasserts.
REQ-030 SHALL, when reset is asserted mid-operation, abandon any outstanding request immediately and ignore its response after reset.

Configuration
REQ-031 SHALL, with macro FETCH_BYPASS_EN defined, present mem_rdata combinationally on instr, op and pc_out with instr_valid high in the mem_rvalid cycle when the buffer is empty; if instr_ready is also high that cycle, the word is consumed without a buffer write.
REQ-032 SHALL, without FETCH_BYPASS_EN, register all outputs so they have no combinational path from any input, giving the one-cycle latency of REQ-023.

Structure
REQ-033 SHALL take the following from shared package riscblade_pkg:
- instruction width (16), PC width (16) and reset vector (0x0000);
- opcode field position [15:12];
- opcode constants: ADD 0000, SUB 1000, ADDI 0001, LW 1001, SW 0010/1010, BR 0011/1011, JAL 0100/1100;
- fetch state enumeration.
REQ-034 SHALL implement the 2-entry instruction/PC buffer as sub-module fetch_fifo, with push, pop, flush, full, empty and count ports.

Verification
REQ-035 SHALL cover reset release: memory grants immediately and returns 0x0123 one cycle later -> mem_addr=0x0000 and then 0x0002; instr=0x0123, op=0x0, pc_out=0x0000.
REQ-036 SHALL cover backpressure: instr_ready held low for 6 cycles -> after 2 responses mem_req stays low; instr and pc_out stay stable; no data is lost once ready rises.
REQ-037 SHALL cover a redirect while a request is outstanding: branch_taken with branch_target=0x0040 -> the stale response is dropped; the next mem_addr is 0x0040; the first pc_out afterwards is 0x0040.
REQ-038 SHALL cover wrap-around: PC reaches 0xFFFE -> the following mem_addr is 0x0000.
REQ-039 SHALL cover a simultaneous pop and write with the buffer full: instr_ready and mem_rvalid high together -> the order is preserved and the count stays 2.
REQ-040 SHALL cover each opcode 0000, 1000, 0001, 1001, 0010, 1010, 0011, 1011, 0100 and 1100, plus mid-stream reset, with and without FETCH_BYPASS_EN -> op matches, with 0-cycle or 1-cycle latency respectively.
